// File: rtl/rc4_ks_ctrl.sv
// RC4 key-schedule and keystream sequencer that owns a 256x8 single-port S-box RAM.
// Build option RC4_DROP_EN: discard the first DROP_N keystream bytes after every keying.
module rc4_ks_ctrl #(
    parameter int KEY_MAX = 32,
    parameter int DROP_N  = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_in,
    input  logic       ks_req,
    output logic       ks_valid,
    output logic [7:0] ks_byte,
    output logic       ready,
    output logic       key_err,
    output logic [7:0] sb_addr,
    output logic       sb_we,
    output logic [7:0] sb_wdata,
    input  logic [7:0] sb_rdata
);
    localparam int LW = $clog2(KEY_MAX + 1);
    localparam int KW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
    localparam int CW = (DROP_N > 256) ? $clog2(DROP_N) : 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_KEY_LOAD  = 3'd1;
    localparam logic [2:0] ST_INIT      = 3'd2;
    localparam logic [2:0] ST_KSA       = 3'd3;
    localparam logic [2:0] ST_PRGA_IDLE = 3'd4;
    localparam logic [2:0] ST_PRGA      = 3'd5;
`ifdef RC4_DROP_EN
    localparam logic [2:0] ST_DROP      = 3'd6;
    localparam logic [2:0] ST_AFTER_KSA = (DROP_N > 0) ? ST_DROP : ST_PRGA_IDLE;
`else
    localparam logic [2:0] ST_AFTER_KSA = ST_PRGA_IDLE;
`endif

    logic [2:0]    state_q, state_d;
    logic [2:0]    phase_q, phase_d;
    logic [7:0]    i_q, i_d;
    logic [7:0]    j_q, j_d;
    logic [7:0]    si_q, si_d;
    logic [7:0]    sj_q, sj_d;
    logic [LW-1:0] len_q, len_d;
    logic [KW-1:0] kidx_q, kidx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          key_err_q, key_err_d;
    logic          ks_valid_q, ks_valid_d;
    logic [7:0]    ks_byte_q, ks_byte_d;
    logic          ready_q, ready_d;
    logic [7:0]    key_mem_q [KEY_MAX];

    logic          key_we_s;
    logic [KW-1:0] key_waddr_s;
    logic [7:0]    key_sel_s;
    logic [7:0]    j_sum_s;
    logic [7:0]    i_inc_s;
    logic          in_drop_s;
    logic          prga_run_s;
    logic [7:0]    sb_addr_s;
    logic          sb_we_s;
    logic [7:0]    sb_wdata_s;

`ifdef RC4_DROP_EN
    assign in_drop_s = (state_q == ST_DROP);
`else
    assign in_drop_s = 1'b0;
`endif
    assign prga_run_s = (state_q == ST_PRGA) || in_drop_s;
    assign key_sel_s  = key_mem_q[kidx_q];

    // Next-state, S-box port and key-capture decode.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        i_d         = i_q;
        j_d         = j_q;
        si_d        = si_q;
        sj_d        = sj_q;
        len_d       = len_q;
        kidx_d      = kidx_q;
        cnt_d       = cnt_q;
        key_err_d   = key_err_q;
        ks_valid_d  = 1'b0;
        ks_byte_d   = ks_byte_q;
        key_we_s    = 1'b0;
        key_waddr_s = {KW{1'b0}};
        j_sum_s     = 8'd0;
        i_inc_s     = 8'd0;
        sb_addr_s   = 8'd0;
        sb_we_s     = 1'b0;
        sb_wdata_s  = 8'd0;
        if (key_valid) begin
            // A key byte always wins and restarts the burst when not already loading.
            state_d  = ST_KEY_LOAD;
            key_we_s = 1'b1;
            if (state_q != ST_KEY_LOAD) begin
                key_waddr_s = {KW{1'b0}};
                len_d       = LW'(1);
                key_err_d   = 1'b0;
            end else if (len_q < LW'(KEY_MAX)) begin
                key_waddr_s = len_q[KW-1:0];
                len_d       = len_q + LW'(1);
            end else begin
                key_we_s  = 1'b0;
                key_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_KEY_LOAD: begin
                    state_d = ST_INIT;
                    cnt_d   = {CW{1'b0}};
                end
                ST_INIT: begin
                    sb_addr_s  = cnt_q[7:0];
                    sb_we_s    = 1'b1;
                    sb_wdata_s = cnt_q[7:0];
                    if (cnt_q[7:0] == 8'hFF) begin
                        state_d = ST_KSA;
                        phase_d = 3'd0;
                        i_d     = 8'd0;
                        j_d     = 8'd0;
                        kidx_d  = {KW{1'b0}};
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_KSA: begin
                    case (phase_q)
                        3'd0: begin
                            sb_addr_s = i_q;
                            phase_d   = 3'd1;
                        end
                        3'd1: begin
                            j_sum_s   = j_q + sb_rdata + key_sel_s;
                            sb_addr_s = j_sum_s;
                            j_d       = j_sum_s;
                            si_d      = sb_rdata;
                            phase_d   = 3'd2;
                        end
                        3'd2: begin
                            sb_addr_s  = i_q;
                            sb_we_s    = 1'b1;
                            sb_wdata_s = sb_rdata;
                            phase_d    = 3'd3;
                        end
                        3'd3: begin
                            sb_addr_s  = j_q;
                            sb_we_s    = 1'b1;
                            sb_wdata_s = si_q;
                            i_d        = i_q + 8'd1;
                            phase_d    = 3'd0;
                            // Key index wraps at the captured length instead of a modulo.
                            if ((LW'(kidx_q) + LW'(1)) == len_q) begin
                                kidx_d = {KW{1'b0}};
                            end else begin
                                kidx_d = kidx_q + KW'(1);
                            end
                            if (i_q == 8'hFF) begin
                                j_d     = 8'd0;
                                cnt_d   = {CW{1'b0}};
                                state_d = ST_AFTER_KSA;
                            end else begin
                                state_d = ST_KSA;
                            end
                        end
                        default: begin
                            phase_d = 3'd0;
                        end
                    endcase
                end
                ST_PRGA_IDLE: begin
                    if (ks_req) begin
                        state_d = ST_PRGA;
                        phase_d = 3'd0;
                    end else begin
                        state_d = ST_PRGA_IDLE;
                    end
                end
                default: begin
                    if (prga_run_s) begin
                        case (phase_q)
                            3'd0: begin
                                i_inc_s   = i_q + 8'd1;
                                sb_addr_s = i_inc_s;
                                i_d       = i_inc_s;
                                phase_d   = 3'd1;
                            end
                            3'd1: begin
                                j_sum_s   = j_q + sb_rdata;
                                sb_addr_s = j_sum_s;
                                j_d       = j_sum_s;
                                si_d      = sb_rdata;
                                phase_d   = 3'd2;
                            end
                            3'd2: begin
                                sb_addr_s  = i_q;
                                sb_we_s    = 1'b1;
                                sb_wdata_s = sb_rdata;
                                sj_d       = sb_rdata;
                                phase_d    = 3'd3;
                            end
                            3'd3: begin
                                sb_addr_s  = j_q;
                                sb_we_s    = 1'b1;
                                sb_wdata_s = si_q;
                                phase_d    = 3'd4;
                            end
                            3'd4: begin
                                sb_addr_s = si_q + sj_q;
                                phase_d   = 3'd5;
                            end
                            3'd5: begin
                                phase_d = 3'd0;
                                if (in_drop_s) begin
                                    if (cnt_q == CW'(DROP_N - 1)) begin
                                        state_d = ST_PRGA_IDLE;
                                        cnt_d   = {CW{1'b0}};
                                    end else begin
                                        cnt_d = cnt_q + CW'(1);
                                    end
                                end else begin
                                    ks_valid_d = 1'b1;
                                    ks_byte_d  = sb_rdata;
                                    state_d    = ST_PRGA_IDLE;
                                end
                            end
                            default: begin
                                phase_d = 3'd0;
                            end
                        endcase
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
        ready_d = (state_d == ST_PRGA_IDLE);
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= 3'd0;
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            si_q       <= 8'd0;
            sj_q       <= 8'd0;
            len_q      <= {LW{1'b0}};
            kidx_q     <= {KW{1'b0}};
            cnt_q      <= {CW{1'b0}};
            key_err_q  <= 1'b0;
            ks_valid_q <= 1'b0;
            ks_byte_q  <= 8'd0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            i_q        <= i_d;
            j_q        <= j_d;
            si_q       <= si_d;
            sj_q       <= sj_d;
            len_q      <= len_d;
            kidx_q     <= kidx_d;
            cnt_q      <= cnt_d;
            key_err_q  <= key_err_d;
            ks_valid_q <= ks_valid_d;
            ks_byte_q  <= ks_byte_d;
            ready_q    <= ready_d;
        end
    end

    // Key byte storage; contents are only meaningful below len_q.
    always_ff @(posedge clk) begin
        if (key_we_s) begin
            key_mem_q[key_waddr_s] <= key_in;
        end
    end

    // The S-box port is combinational so a read address can follow data from the previous read.
    assign sb_addr  = rst ? sb_addr_s  : 8'd0;
    assign sb_we    = rst ? sb_we_s    : 1'b0;
    assign sb_wdata = rst ? sb_wdata_s : 8'd0;
    assign ks_valid = ks_valid_q;
    assign ks_byte  = ks_byte_q;
    assign ready    = ready_q;
    assign key_err  = key_err_q;
endmodule

// File: tb/tb_rc4_ks_ctrl.sv
// Bench for rc4_ks_ctrl: behavioural S-box RAM, plain RC4 reference model, directed and random keys.
module tb_rc4_ks_ctrl;
    localparam int KEY_MAX = 32;
    localparam int DROP_N  = 4;
`ifdef RC4_DROP_EN
    localparam int SKIP = DROP_N;
`else
    localparam int SKIP = 0;
`endif
    localparam int READY_LAT = 1 + 256 + 1024 + 6 * SKIP;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_in = 8'd0;
    logic       ks_req = 1'b0;
    logic       ks_valid;
    logic [7:0] ks_byte;
    logic       ready;
    logic       key_err;
    logic [7:0] sb_addr;
    logic       sb_we;
    logic [7:0] sb_wdata;
    logic [7:0] sb_rdata;

    logic [7:0] sbox_mem [256];
    int pass_cnt = 0;
    int total_cnt = 0;
    int stray_seen = 0;

    rc4_ks_ctrl #(.KEY_MAX(KEY_MAX), .DROP_N(DROP_N)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_in(key_in),
        .ks_req(ks_req), .ks_valid(ks_valid), .ks_byte(ks_byte), .ready(ready),
        .key_err(key_err), .sb_addr(sb_addr), .sb_we(sb_we), .sb_wdata(sb_wdata),
        .sb_rdata(sb_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sb_we) sbox_mem[sb_addr] <= sb_wdata;
        sb_rdata <= sbox_mem[sb_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Textbook RC4 on an integer array; keys longer than KEY_MAX are truncated.
    function automatic byte_q_t rc4_ref(input byte_q_t key, input int n);
        int s[256];
        int i, j, t, klen;
        byte_q_t ks;
        klen = (key.size() > KEY_MAX) ? KEY_MAX : key.size();
        for (int k = 0; k < 256; k++) s[k] = k;
        j = 0;
        for (int k = 0; k < 256; k++) begin
            j = (j + s[k] + int'(key[k % klen])) % 256;
            t = s[k]; s[k] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        for (int k = 0; k < n + SKIP; k++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            if (k >= SKIP) ks.push_back(8'(s[(s[i] + s[j]) % 256]));
        end
        return ks;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input byte_q_t key);
        foreach (key[k]) begin
            key_valid = 1'b1;
            key_in = key[k];
            tick();
            if (ks_valid) stray_seen++;
        end
        key_valid = 1'b0;
        key_in = 8'd0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 5000) begin
            tick();
            n++;
            if (ks_valid) stray_seen++;
        end
        check({tag, "_ready_lat"}, n, READY_LAT);
        check({tag, "_no_stray_valid"}, stray_seen, 0);
        stray_seen = 0;
    endtask

    // Request n bytes (held or pulsed) and compare with the model and any known vector.
    task automatic get_stream(input string tag, input byte_q_t key, input int n,
                              input bit hold, input byte_q_t known);
        byte_q_t exp;
        int lat;
        exp = rc4_ref(key, n);
        for (int k = 0; k < n; k++) begin
            ks_req = 1'b1;
            lat = 0;
            do begin
                tick();
                lat++;
                if (lat == 1) begin
                    check({tag, "_ready_drop"}, ready, 1'b0);
                    if (!hold) ks_req = 1'b0;
                end
            end while (ks_valid !== 1'b1 && lat < 64);
            if (hold && k == n - 1) ks_req = 1'b0;
            check({tag, "_valid_lat"}, lat, 7);
            check({tag, "_byte_model"}, ks_byte, exp[k]);
            if (k + SKIP < known.size()) check({tag, "_byte_known"}, ks_byte, known[k + SKIP]);
            if (!hold) begin
                tick();
                check({tag, "_pulse_width"}, ks_valid, 1'b0);
                check({tag, "_byte_hold"}, ks_byte, exp[k]);
                repeat ($urandom_range(0, 4)) tick();
            end
        end
        ks_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ks_valid"}, ks_valid, 1'b0);
        check({tag, "_ks_byte"}, ks_byte, 8'd0);
        check({tag, "_ready"}, ready, 1'b0);
        check({tag, "_key_err"}, key_err, 1'b0);
        check({tag, "_sb_we"}, sb_we, 1'b0);
        check({tag, "_sb_addr"}, sb_addr, 8'd0);
        check({tag, "_sb_wdata"}, sb_wdata, 8'd0);
    endtask

    function automatic byte_q_t rand_key(input int len);
        byte_q_t q;
        for (int k = 0; k < len; k++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        byte_q_t k_key, k_wiki, k_secret, k_long, k_new, k_rand, none;
        byte_q_t v_key, v_wiki, v_secret;
        k_key    = '{8'h4B, 8'h65, 8'h79};
        k_wiki   = '{8'h57, 8'h69, 8'h6B, 8'h69};
        k_secret = '{8'h53, 8'h65, 8'h63, 8'h72, 8'h65, 8'h74};
        v_key    = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        v_wiki   = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41};
        v_secret = '{8'h04, 8'hD4};

        repeat (2) tick();
        check_reset_outputs("por");
        rst = 1'b1;
        tick();
        check("idle_ready", ready, 1'b0);

        send_key(k_key);
        wait_ready("key");
        get_stream("key", k_key, 10, 1'b1, v_key);

        send_key(k_wiki);
        wait_ready("wiki");
        get_stream("wiki", k_wiki, 5, 1'b0, v_wiki);

        k_long = rand_key(33);
        send_key(k_long);
        check("long_key_err", key_err, 1'b1);
        wait_ready("long");
        get_stream("long", k_long, 6, 1'b1, none);
        check("long_key_err_sticky", key_err, 1'b1);

        send_key(k_secret);
        check("secret_key_err_clr", key_err, 1'b0);
        wait_ready("secret");
        get_stream("secret", k_secret, 4, 1'b0, v_secret);

        // Rekey while the in-flight byte is in its first write cycle.
        ks_req = 1'b1;
        tick();
        ks_req = 1'b0;
        repeat (2) tick();
        k_new = rand_key(7);
        send_key(k_new);
        wait_ready("rekey");
        get_stream("rekey", k_new, 6, 1'b1, none);

        k_long = rand_key(33);
        send_key(k_long);
        repeat (600) tick();
        rst = 1'b0;
        for (int r = 0; r < 3; r++) begin
            tick();
            check_reset_outputs("mid_ksa_rst");
        end
        rst = 1'b1;
        send_key(k_key);
        wait_ready("post_rst");
        get_stream("post_rst", k_key, 3, 1'b1, v_key);

        for (int it = 0; it < 4; it++) begin
            int len;
            bit hold;
            len = $urandom_range(1, 34);
            hold = 1'($urandom_range(0, 1));
            k_rand = rand_key(len);
            send_key(k_rand);
            check("rand_key_err", key_err, (len > KEY_MAX) ? 1'b1 : 1'b0);
            wait_ready("rand");
            get_stream("rand", k_rand, 5, hold, none);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
